// File: rtl/crc_pkg.sv
// Shared types and helpers for the bit-serial CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_AUG   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Width of a counter that must hold the value crc_w.
    function automatic int cnt_width(input int crc_w);
        return $clog2(crc_w + 1);
    endfunction

endpackage

// File: rtl/crc_div_step.sv
// One long-division step: shift in a bit, subtract POLY when the top bit falls out.
module crc_div_step #(
    parameter int               CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = 3'b011
) (
    input  logic [CRC_W-1:0] r_in,
    input  logic             bit_in,
    output logic [CRC_W-1:0] r_out
);

    assign r_out = {r_in[CRC_W-2:0], bit_in} ^ (r_in[CRC_W-1] ? POLY : '0);

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker, one frame at a time with valid/ready on both sides.
// CRC_AUGMENT_EN builds the internal zero-append phase; without it the source appends the zeros.
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 3,
    parameter logic [CRC_W-1:0] POLY    = 3'b011,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CRC_W-1:0] out_crc,
    output logic             out_ok
);

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   r_q, r_d;
    logic               mode_q, mode_d;
    logic               out_valid_q, out_valid_d;
    logic [CRC_W-1:0]   out_crc_q, out_crc_d;
    logic               out_ok_q, out_ok_d;
`ifdef CRC_AUGMENT_EN
    localparam int CNT_W = cnt_width(CRC_W);
    logic [CNT_W-1:0]   zcnt_q, zcnt_d;
`endif

    logic [CRC_W-1:0]   step_r;
    logic               step_b;
    logic [CRC_W-1:0]   step_out;
    logic               accept;
    logic               mode_eff;
    logic               finish;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_SHIFT);
    assign accept    = in_valid && in_ready;
    // The mode travels with the first bit, so IDLE uses the live input.
    assign mode_eff  = (state_q == ST_IDLE) ? in_mode : mode_q;
    assign out_valid = out_valid_q;
    assign out_crc   = out_crc_q;
    assign out_ok    = out_ok_q;

    always_comb begin
        step_r = (state_q == ST_IDLE) ? INIT : r_q;
        step_b = in_bit;
`ifdef CRC_AUGMENT_EN
        if (state_q == ST_AUG) begin
            step_b = 1'b0;
        end
`endif
    end

    crc_div_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .r_in   (step_r),
        .bit_in (step_b),
        .r_out  (step_out)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_crc_d   = out_crc_q;
        out_ok_d    = out_ok_q;
        finish      = 1'b0;
`ifdef CRC_AUGMENT_EN
        zcnt_d      = zcnt_q;
`endif

        case (state_q)
            ST_IDLE, ST_SHIFT: begin
                if (accept) begin
                    r_d = step_out;
                    if (state_q == ST_IDLE) begin
                        mode_d = in_mode;
                    end
                    if (in_last) begin
`ifdef CRC_AUGMENT_EN
                        if (mode_eff == MODE_GEN) begin
                            state_d = ST_AUG;
                            zcnt_d  = CNT_W'(CRC_W);
                        end else begin
                            finish = 1'b1;
                        end
`else
                        finish = 1'b1;
`endif
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
`ifdef CRC_AUGMENT_EN
            ST_AUG: begin
                r_d    = step_out;
                zcnt_d = zcnt_q - CNT_W'(1);
                if (zcnt_q == CNT_W'(1)) begin
                    finish = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    r_d         = INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The result is taken from the step output so it lands on the same edge as the final shift.
        if (finish) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            out_crc_d   = (mode_eff == MODE_GEN) ? (step_out ^ XOR_OUT) : step_out;
            out_ok_d    = (mode_eff == MODE_CHK) && (step_out == '0);
        end

        if (clr) begin
            state_d     = ST_IDLE;
            r_d         = INIT;
            mode_d      = MODE_GEN;
            out_valid_d = 1'b0;
            out_crc_d   = '0;
            out_ok_d    = 1'b0;
`ifdef CRC_AUGMENT_EN
            zcnt_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            r_q         <= INIT;
            mode_q      <= MODE_GEN;
            out_valid_q <= 1'b0;
            out_crc_q   <= '0;
            out_ok_q    <= 1'b0;
`ifdef CRC_AUGMENT_EN
            zcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_crc_q   <= out_crc_d;
            out_ok_q    <= out_ok_d;
`ifdef CRC_AUGMENT_EN
            zcnt_q      <= zcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine with CRC_W=3, POLY=x^3+x+1; adapts to either CRC_AUGMENT_EN build.
module tb_crc_serial_engine;
    import crc_pkg::*;

    localparam int W = 3;
`ifdef CRC_AUGMENT_EN
    localparam int GEN_LAT   = W;
    localparam bit AUG_BUILD = 1'b1;
`else
    localparam int GEN_LAT   = 0;
    localparam bit AUG_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_bit = 1'b0;
    logic         in_last = 1'b0;
    logic         in_mode = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic         out_ok;
    logic [W-1:0] out_crc;

    int n_chk  = 0;
    int n_fail = 0;

    crc_serial_engine #(
        .CRC_W   (W),
        .POLY    (3'b011),
        .INIT    (3'b000),
        .XOR_OUT (3'b000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc),
        .out_ok    (out_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends a frame MSB-first; later bits carry the opposite in_mode, which must be ignored.
    task automatic send_frame(input logic [31:0] v, input int len, input logic mode, input bit bubble);
        int          total;
        logic [31:0] bits;
        total = len;
        bits  = v;
        if (!AUG_BUILD && mode == MODE_GEN) begin
            bits  = v << W;
            total = len + W;
        end
        chk("ready_at_start", in_ready, 1);
        for (int i = 0; i < total; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[total-1-i];
            in_last  = (i == total - 1);
            in_mode  = (i == 0) ? mode : ~mode;
            tick();
            if (bubble && i != total - 1) begin
                in_valid = 1'b0;
                in_bit   = ~in_bit;
                in_last  = 1'b1;
                tick();
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int lat, input logic [W-1:0] ecrc, input logic eok);
        for (int k = 0; k < lat; k++) begin
            chk({tag, "_early"}, out_valid, 0);
            tick();
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_crc"}, out_crc, ecrc);
        chk({tag, "_ok"}, out_ok, eok);
        chk({tag, "_stall_in"}, in_ready, 0);
    endtask

    task automatic consume(input string tag);
        tick();
        chk({tag, "_drop"}, out_valid, 0);
        chk({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_crc", out_crc, 0);
        chk("rst_ok", out_ok, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        send_frame(32'b10101, 5, MODE_GEN, 1'b0);
        expect_result("gen10101", GEN_LAT, 3'b101, 1'b0);
        consume("gen10101");

        send_frame(32'b10101101, 8, MODE_CHK, 1'b1);
        expect_result("chk_good", 0, 3'b000, 1'b1);
        consume("chk_good");

        send_frame(32'b10101100, 8, MODE_CHK, 1'b0);
        expect_result("chk_bad", 0, 3'b001, 1'b0);
        consume("chk_bad");

        send_frame(32'b1, 1, MODE_GEN, 1'b0);
        expect_result("gen_one", GEN_LAT, 3'b011, 1'b0);
        consume("gen_one");

        // Consumer stalls in DONE while the source keeps offering bits.
        out_ready = 1'b0;
        send_frame(32'b10101, 5, MODE_GEN, 1'b0);
        expect_result("stall", GEN_LAT, 3'b101, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_bit   = 1'b1;
            in_last  = 1'b1;
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_crc", out_crc, 3'b101);
            chk("stall_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        consume("stall");
        send_frame(32'b10101100, 8, MODE_CHK, 1'b0);
        expect_result("after_stall", 0, 3'b001, 1'b0);
        consume("after_stall");

        // Abort a partial frame with clr.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            in_last  = 1'b0;
            in_mode  = MODE_GEN;
            tick();
        end
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ready", in_ready, 1);
        chk("clr_valid", out_valid, 0);
        chk("clr_crc", out_crc, 0);
        send_frame(32'b10101, 5, MODE_GEN, 1'b0);
        expect_result("after_clr", GEN_LAT, 3'b101, 1'b0);
        consume("after_clr");

        // Asynchronous reset during zero-augmentation (or in DONE when not built).
        send_frame(32'b10101, 5, MODE_GEN, 1'b0);
        if (AUG_BUILD) begin
            tick();
            chk("mid_aug_busy", in_ready, 0);
        end
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_crc", out_crc, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        send_frame(32'b1, 1, MODE_GEN, 1'b0);
        expect_result("after_rst", GEN_LAT, 3'b011, 1'b0);
        consume("after_rst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
